// File: rtl/axi_wr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_wr_pkg
// Description : Shared types and constants for the posted-write buffer that
//               sits between the dcache write port and the AXI AW/W/B
//               channels. Holds the write-type codes, the AXI size, burst and
//               response codes, the drain FSM state encoding and the FIFO
//               entry layout.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package axi_wr_pkg;

    // dcache write types
    localparam logic [2:0] c_WR_TYPE_BYTE = 3'b000;
    localparam logic [2:0] c_WR_TYPE_HALF = 3'b001;
    localparam logic [2:0] c_WR_TYPE_WORD = 3'b010;
    localparam logic [2:0] c_WR_TYPE_LINE = 3'b100;

    // AXI encodings
    localparam logic [2:0] c_AXI_SIZE_1B     = 3'd0;
    localparam logic [2:0] c_AXI_SIZE_2B     = 3'd1;
    localparam logic [2:0] c_AXI_SIZE_4B     = 3'd2;
    localparam logic [1:0] c_AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] c_AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] c_AXI_RESP_OKAY   = 2'b00;
    localparam logic [7:0] c_AXI_LEN_LINE    = 8'd3;   // 4 beats of 32 bits
    localparam logic [7:0] c_AXI_LEN_SINGLE  = 8'd0;

    // Drain FSM state encoding
    localparam int         c_STATE_W = 2;
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_AW   = 2'd1;
    localparam logic [1:0] c_ST_W    = 2'd2;
    localparam logic [1:0] c_ST_B    = 2'd3;

    // One buffered write
    typedef struct packed {
        logic [2:0]   wr_type;
        logic [31:0]  addr;
        logic [3:0]   wstrb;
        logic [127:0] data;
    } wr_entry_t;

endpackage
`default_nettype wire

// File: rtl/wr_buf_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wr_buf_fifo
// Description : In-order storage for buffered writes. Head entry remains
//               valid until popped so it is still covered by the line
//               hazard compare while its AXI transaction is in flight.
// Ports       : clk, rst_n        - clock, async active-low reset
//               i_push, i_entry   - write a new entry at the tail (ignored when full)
//               i_pop             - retire the head entry (ignored when empty)
//               o_head            - entry at the head
//               o_full, o_empty   - occupancy flags
//               i_chk_tag         - line tag (addr[31:4]) to compare
//               o_chk_hit         - a valid entry holds that line
// Revision    : 1.0 - initial release
// ============================================================================
module wr_buf_fifo
    import axi_wr_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_push,
    input  wr_entry_t   i_entry,
    input  logic        i_pop,
    output wr_entry_t   o_head,
    output logic        o_full,
    output logic        o_empty,
    input  logic [27:0] i_chk_tag,
    output logic        o_chk_hit
);

    localparam int c_AW = $clog2(DEPTH);

    wr_entry_t         r_mem [DEPTH];
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_AW:0]     r_count;
    logic              w_push;
    logic              w_pop;
    logic [DEPTH-1:0]  w_hit;

    assign o_full  = (r_count == (c_AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    // A full buffer refuses pushes even when the head retires this cycle.
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_head  = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_AW+1)'(1);
                2'b01:   r_count <= r_count - (c_AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: slots outside [rd_ptr, rd_ptr+count) are masked.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_entry;
    end

    // Slot i is live when its distance from the head is below the count.
    for (genvar i = 0; i < DEPTH; i++) begin : g_tag_cmp
        logic [c_AW-1:0] w_off;
        assign w_off    = c_AW'(i) - r_rd_ptr;
        assign w_hit[i] = ({1'b0, w_off} < r_count) &&
                          (r_mem[i].addr[31:4] == i_chk_tag);
    end

    assign o_chk_hit = |w_hit;

endmodule
`default_nettype wire

// File: rtl/axi_wr_buffer.sv
`default_nettype none
// ============================================================================
// Module      : axi_wr_buffer
// Description : Posted-write buffer. Accepts dcache line evictions and
//               uncached stores, queues them, and drains them in order as
//               single AXI write transactions with one outstanding at a time.
// Ports       : clk, rst_n              - clock, async active-low reset
//               i_wr_*, o_wr_rdy        - dcache write request interface
//               i_chk_addr, o_chk_hit   - same-line hazard check for reads
//               o_wr_buf_empty          - nothing queued or in flight
//               o_bresp_err             - sticky error on non-OKAY bresp
//               o_aw*, o_w*, o_bready   - AXI master outputs
//               i_awready, i_wready,
//               i_bid, i_bresp, i_bvalid - AXI master inputs
// Revision    : 1.0 - initial release
// ============================================================================
module axi_wr_buffer
    import axi_wr_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int ID_WIDTH = 4,
    parameter int AXI_ID   = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_wr_req,
    input  logic [2:0]          i_wr_type,
    input  logic [31:0]         i_wr_addr,
    input  logic [3:0]          i_wr_wstrb,
    input  logic [127:0]        i_wr_data,
    output logic                o_wr_rdy,
    input  logic [31:0]         i_chk_addr,
    output logic                o_chk_hit,
    output logic                o_wr_buf_empty,
    output logic                o_bresp_err,
    output logic [ID_WIDTH-1:0] o_awid,
    output logic [31:0]         o_awaddr,
    output logic [7:0]          o_awlen,
    output logic [2:0]          o_awsize,
    output logic [1:0]          o_awburst,
    output logic [1:0]          o_awlock,
    output logic [3:0]          o_awcache,
    output logic [2:0]          o_awprot,
    output logic                o_awvalid,
    output logic [ID_WIDTH-1:0] o_wid,
    output logic [31:0]         o_wdata,
    output logic [3:0]          o_wstrb,
    output logic                o_wlast,
    output logic                o_wvalid,
    output logic                o_bready,
    input  logic                i_awready,
    input  logic                i_wready,
    input  logic [ID_WIDTH-1:0] i_bid,
    input  logic [1:0]          i_bresp,
    input  logic                i_bvalid
);

    wr_entry_t              w_entry;
    wr_entry_t              w_head;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_pop;
    logic [1:0]             w_beat_nxt;
    logic                   w_unused;

    logic [c_STATE_W-1:0]   r_state;
    logic [1:0]             r_beat_cnt;
    logic                   r_is_line;
    logic [3:0]             r_ent_wstrb;
    logic [127:0]           r_data;
    logic [31:0]            r_awaddr;
    logic [7:0]             r_awlen;
    logic [2:0]             r_awsize;
    logic                   r_awvalid;
    logic [31:0]            r_wdata;
    logic [3:0]             r_wstrb;
    logic                   r_wlast;
    logic                   r_wvalid;
    logic                   r_bready;
    logic                   r_bresp_err;

    assign w_entry = '{wr_type: i_wr_type, addr: i_wr_addr,
                       wstrb: i_wr_wstrb, data: i_wr_data};
    // The head is retired only once its write response arrives.
    assign w_pop      = (r_state == c_ST_B) && i_bvalid;
    assign w_beat_nxt = r_beat_cnt + 2'd1;
    assign w_unused   = &{1'b0, i_bid};

    wr_buf_fifo #(
        .DEPTH     (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_push    (i_wr_req),
        .i_entry   (w_entry),
        .i_pop     (w_pop),
        .o_head    (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .i_chk_tag (i_chk_addr[31:4]),
        .o_chk_hit (o_chk_hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_ST_IDLE;
            r_beat_cnt  <= '0;
            r_is_line   <= 1'b0;
            r_ent_wstrb <= '0;
            r_data      <= '0;
            r_awaddr    <= '0;
            r_awlen     <= '0;
            r_awsize    <= '0;
            r_awvalid   <= 1'b0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_wlast     <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_bresp_err <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (!w_empty) begin
                        r_is_line   <= (w_head.wr_type == c_WR_TYPE_LINE);
                        r_ent_wstrb <= w_head.wstrb;
                        r_data      <= w_head.data;
                        r_beat_cnt  <= '0;
                        if (w_head.wr_type == c_WR_TYPE_LINE) begin
                            r_awaddr <= {w_head.addr[31:4], 4'h0};
                            r_awlen  <= c_AXI_LEN_LINE;
                            r_awsize <= c_AXI_SIZE_4B;
                        end else begin
                            r_awaddr <= w_head.addr;
                            r_awlen  <= c_AXI_LEN_SINGLE;
                            r_awsize <= {1'b0, w_head.wr_type[1:0]};
                        end
                        r_awvalid <= 1'b1;
                        r_state   <= c_ST_AW;
                    end
                end
                c_ST_AW: begin
                    if (i_awready) begin
                        r_awvalid <= 1'b0;
                        r_wvalid  <= 1'b1;
                        r_wdata   <= r_data[31:0];
                        r_wstrb   <= r_is_line ? 4'hF : r_ent_wstrb;
                        r_wlast   <= !r_is_line;
                        r_state   <= c_ST_W;
                    end
                end
                c_ST_W: begin
                    if (i_wready) begin
                        if (r_wlast) begin
                            r_wvalid <= 1'b0;
                            r_bready <= 1'b1;
                            r_state  <= c_ST_B;
                        end else begin
                            // Preload the next beat so wdata/wlast stay registered.
                            r_beat_cnt <= w_beat_nxt;
                            r_wdata    <= r_data[{w_beat_nxt, 5'd0} +: 32];
                            r_wlast    <= (w_beat_nxt == 2'd3);
                        end
                    end
                end
                default: begin
                    if (i_bvalid) begin
                        r_bready <= 1'b0;
                        if (i_bresp != c_AXI_RESP_OKAY) r_bresp_err <= 1'b1;
                        r_state  <= c_ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign o_wr_rdy       = !w_full;
    assign o_wr_buf_empty = w_empty;
    assign o_bresp_err    = r_bresp_err;
    assign o_awid         = ID_WIDTH'(AXI_ID);
    assign o_awaddr       = r_awaddr;
    assign o_awlen        = r_awlen;
    assign o_awsize       = r_awsize;
    assign o_awburst      = c_AXI_BURST_INCR;
    assign o_awlock       = 2'b00;
    assign o_awcache      = 4'h0;
    assign o_awprot       = 3'h0;
    assign o_awvalid      = r_awvalid;
    assign o_wid          = ID_WIDTH'(AXI_ID);
    assign o_wdata        = r_wdata;
    assign o_wstrb        = r_wstrb;
    assign o_wlast        = r_wlast;
    assign o_wvalid       = r_wvalid;
    assign o_bready       = r_bready;

endmodule
`default_nettype wire

// File: tb/tb_axi_wr_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_wr_buffer
// Description : Self-checking bench for axi_wr_buffer. Expected AW and W
//               traffic is queued when a write is accepted and compared when
//               the DUT handshakes on the AXI channels.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_wr_buffer;
    import axi_wr_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         i_wr_req = 1'b0;
    logic [2:0]   i_wr_type = '0;
    logic [31:0]  i_wr_addr = '0;
    logic [3:0]   i_wr_wstrb = '0;
    logic [127:0] i_wr_data = '0;
    logic         o_wr_rdy;
    logic [31:0]  i_chk_addr = '0;
    logic         o_chk_hit;
    logic         o_wr_buf_empty;
    logic         o_bresp_err;
    logic [3:0]   o_awid;
    logic [31:0]  o_awaddr;
    logic [7:0]   o_awlen;
    logic [2:0]   o_awsize;
    logic [1:0]   o_awburst;
    logic [1:0]   o_awlock;
    logic [3:0]   o_awcache;
    logic [2:0]   o_awprot;
    logic         o_awvalid;
    logic [3:0]   o_wid;
    logic [31:0]  o_wdata;
    logic [3:0]   o_wstrb;
    logic         o_wlast;
    logic         o_wvalid;
    logic         o_bready;
    logic         i_awready = 1'b0;
    logic         i_wready = 1'b0;
    logic [3:0]   i_bid = '0;
    logic [1:0]   i_bresp = '0;
    logic         i_bvalid = 1'b0;

    axi_wr_buffer #(.DEPTH(4), .ID_WIDTH(4), .AXI_ID(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_wr_req(i_wr_req), .i_wr_type(i_wr_type), .i_wr_addr(i_wr_addr),
        .i_wr_wstrb(i_wr_wstrb), .i_wr_data(i_wr_data), .o_wr_rdy(o_wr_rdy),
        .i_chk_addr(i_chk_addr), .o_chk_hit(o_chk_hit),
        .o_wr_buf_empty(o_wr_buf_empty), .o_bresp_err(o_bresp_err),
        .o_awid(o_awid), .o_awaddr(o_awaddr), .o_awlen(o_awlen),
        .o_awsize(o_awsize), .o_awburst(o_awburst), .o_awlock(o_awlock),
        .o_awcache(o_awcache), .o_awprot(o_awprot), .o_awvalid(o_awvalid),
        .o_wid(o_wid), .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wlast(o_wlast),
        .o_wvalid(o_wvalid), .o_bready(o_bready),
        .i_awready(i_awready), .i_wready(i_wready), .i_bid(i_bid),
        .i_bresp(i_bresp), .i_bvalid(i_bvalid)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        chk_burst;
    } aw_t;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } w_t;

    aw_t aw_q[$];
    w_t  w_q[$];

    // Slave-side behaviour knobs, written by the stimulus block.
    logic       aw_cfg = 1'b1;
    logic       w_cfg  = 1'b1;
    logic       w_rand = 1'b0;
    logic [1:0] b_resp_cfg = 2'b00;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Slave driver: updates 1 time unit after the rising edge; B is a
    // one-cycle pulse answering each bready.
    always @(posedge clk) begin
        #1;
        i_awready = aw_cfg;
        i_wready  = w_rand ? 1'($urandom_range(0, 1)) : w_cfg;
        i_bvalid  = o_bready && !i_bvalid;
        i_bresp   = b_resp_cfg;
    end

    // Channel monitor on the falling edge.
    logic aw_hold = 1'b0;
    logic w_hold  = 1'b0;
    aw_t  aw_prev, am;
    w_t   w_prev, wm;

    always @(negedge clk) begin
        if (!rst_n) begin
            aw_hold = 1'b0;
            w_hold  = 1'b0;
        end else begin
            if (aw_hold) begin
                check("aw_hold_valid", o_awvalid, 1'b1);
                check("aw_hold_addr", o_awaddr, aw_prev.addr);
                check("aw_hold_len", o_awlen, aw_prev.len);
                check("aw_hold_size", o_awsize, aw_prev.size);
            end
            if (w_hold) begin
                check("w_hold_valid", o_wvalid, 1'b1);
                check("w_hold_data", o_wdata, w_prev.data);
                check("w_hold_strb", o_wstrb, w_prev.strb);
                check("w_hold_last", o_wlast, w_prev.last);
            end
            if (o_awvalid && i_awready) begin
                total++;
                assert (aw_q.size() > 0) else begin
                    bad++;
                    $error("FAIL aw_extra observed=%0h expected=none", o_awaddr);
                end
                if (aw_q.size() > 0) begin
                    am = aw_q.pop_front();
                    check("awaddr", o_awaddr, am.addr);
                    check("awlen", o_awlen, am.len);
                    check("awsize", o_awsize, am.size);
                    if (am.chk_burst) check("awburst", o_awburst, am.burst);
                    check("awid", o_awid, 4'd1);
                    check("aw_lock_cache_prot", {o_awlock, o_awcache, o_awprot}, 9'd0);
                end
            end
            if (o_wvalid && i_wready) begin
                total++;
                assert (w_q.size() > 0) else begin
                    bad++;
                    $error("FAIL w_extra observed=%0h expected=none", o_wdata);
                end
                if (w_q.size() > 0) begin
                    wm = w_q.pop_front();
                    check("wdata", o_wdata, wm.data);
                    check("wstrb", o_wstrb, wm.strb);
                    check("wlast", o_wlast, wm.last);
                    check("wid", o_wid, 4'd1);
                end
            end
            aw_hold = o_awvalid && !i_awready;
            aw_prev = '{o_awaddr, o_awlen, o_awsize, o_awburst, 1'b0};
            w_hold  = o_wvalid && !i_wready;
            w_prev  = '{o_wdata, o_wstrb, o_wlast};
        end
    end

    // Stimulus steps sit 2 time units after the rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [2:0] t, input logic [31:0] a,
                        input logic [3:0] s, input logic [127:0] d);
        logic acc;
        i_wr_req   = 1'b1;
        i_wr_type  = t;
        i_wr_addr  = a;
        i_wr_wstrb = s;
        i_wr_data  = d;
        acc = o_wr_rdy;
        if (acc) begin
            if (t == c_WR_TYPE_LINE) begin
                aw_q.push_back('{{a[31:4], 4'h0}, 8'd3, 3'd2, 2'b01, 1'b1});
                for (int n = 0; n < 4; n++)
                    w_q.push_back('{d[n*32 +: 32], 4'hF, (n == 3)});
            end else begin
                aw_q.push_back('{a, 8'd0, {1'b0, t[1:0]}, 2'b01, 1'b0});
                w_q.push_back('{d[31:0], s, 1'b1});
            end
        end
        step();
        i_wr_req = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (!(o_wr_buf_empty && !o_bready && aw_q.size() == 0 && w_q.size() == 0)
               && n < 300) begin
            step();
            n++;
        end
        total++;
        assert (n < 300) else begin
            bad++;
            $error("FAIL %s observed=busy expected=idle", tag);
        end
    endtask

    task automatic wait_bhs(input string tag);
        int n = 0;
        while (!(i_bvalid && o_bready) && n < 100) begin
            step();
            n++;
        end
        total++;
        assert (n < 100) else begin
            bad++;
            $error("FAIL %s observed=no_bvalid expected=bvalid", tag);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        rst_n = 1'b0;
        repeat (3) step();
        check("rst_wr_rdy", o_wr_rdy, 1'b1);
        check("rst_empty", o_wr_buf_empty, 1'b1);
        check("rst_bresp_err", o_bresp_err, 1'b0);
        check("rst_valids", {o_awvalid, o_wvalid, o_bready}, 3'b000);
        i_chk_addr = 32'h0000_1000; #1;
        check("rst_chk_hit_a", o_chk_hit, 1'b0);
        i_chk_addr = $urandom; #1;
        check("rst_chk_hit_b", o_chk_hit, 1'b0);
        rst_n = 1'b1;
        step();

        // Line write, all readies high
        push(c_WR_TYPE_LINE, 32'h0000_1000, 4'h0,
             128'h44444444_33333333_22222222_11111111);
        check("t1_empty_next_cycle", o_wr_buf_empty, 1'b0);
        check("t1_awvalid_early", o_awvalid, 1'b0);
        i_chk_addr = 32'h0000_1008; #1;
        check("t1_chk_hit", o_chk_hit, 1'b1);
        step();
        check("t1_awvalid_2cyc", o_awvalid, 1'b1);
        wait_bhs("t1_bvalid");
        check("t1_empty_at_bvalid", o_wr_buf_empty, 1'b0);
        step();
        check("t1_empty_after_b", o_wr_buf_empty, 1'b1);
        wait_idle("t1_idle");

        // Byte store
        push(c_WR_TYPE_BYTE, 32'h0000_2003, 4'b1000, 128'hAB00_0000);
        wait_idle("t2_idle");

        // Fill the buffer while AW is stalled
        aw_cfg = 1'b0;
        step();
        for (int i = 0; i < 4; i++)
            push(c_WR_TYPE_LINE, 32'h0000_4000 + 32'(i * 16), 4'h0,
                 {32'hC0DE_0003 + 32'(i * 16), 32'hC0DE_0002 + 32'(i * 16),
                  32'hC0DE_0001 + 32'(i * 16), 32'hC0DE_0000 + 32'(i * 16)});
        check("t3_full_wr_rdy", o_wr_rdy, 1'b0);
        i_chk_addr = 32'h0000_401C; #1;
        check("t3_chk_hit_queued", o_chk_hit, 1'b1);
        i_chk_addr = 32'h0000_4040; #1;
        check("t3_chk_miss", o_chk_hit, 1'b0);
        push(c_WR_TYPE_LINE, 32'h0000_5000, 4'h0, {4{32'hDEAD_BEEF}});
        aw_cfg = 1'b1;
        wait_bhs("t3_first_b");
        check("t3_rdy_at_bvalid", o_wr_rdy, 1'b0);
        step();
        check("t3_rdy_after_pop", o_wr_rdy, 1'b1);
        wait_idle("t3_idle");

        // Hazard compare against a queued line
        aw_cfg = 1'b0;
        step();
        push(c_WR_TYPE_LINE, 32'h0000_3010, 4'h0, {4{32'h5A5A_5A5A}});
        i_chk_addr = 32'h0000_301C; #1;
        check("t4_hit_same_line", o_chk_hit, 1'b1);
        i_chk_addr = 32'h0000_3020; #1;
        check("t4_miss_next_line", o_chk_hit, 1'b0);
        aw_cfg = 1'b1;
        wait_idle("t4_idle");
        i_chk_addr = 32'h0000_301C; #1;
        check("t4_miss_after_b", o_chk_hit, 1'b0);

        // Random wready back-pressure
        w_rand = 1'b1;
        push(c_WR_TYPE_LINE, 32'h0000_6000, 4'h0,
             128'h6666_0004_6666_0003_6666_0002_6666_0001);
        push(c_WR_TYPE_HALF, 32'h0000_6102, 4'b1100, 128'h1234_0000);
        push(c_WR_TYPE_LINE, 32'h0000_6010, 4'h0,
             128'h7777_0004_7777_0003_7777_0002_7777_0001);
        wait_idle("t5_idle");
        w_rand = 1'b0;

        // Sticky bresp error
        b_resp_cfg = 2'b10;
        push(c_WR_TYPE_WORD, 32'h0000_7000, 4'hF, 128'hCAFE_F00D);
        wait_idle("t6_idle_err");
        check("t6_bresp_err_set", o_bresp_err, 1'b1);
        b_resp_cfg = 2'b00;
        push(c_WR_TYPE_WORD, 32'h0000_7004, 4'hF, 128'h0BAD_CAFE);
        wait_idle("t6_idle_ok");
        check("t6_bresp_err_sticky", o_bresp_err, 1'b1);

        // Reset during the W phase with two entries queued
        w_cfg = 1'b0;
        step();
        push(c_WR_TYPE_LINE, 32'h0000_8000, 4'h0, {4{32'h8888_8888}});
        push(c_WR_TYPE_LINE, 32'h0000_8010, 4'h0, {4{32'h9999_9999}});
        begin
            int n = 0;
            while (!o_wvalid && n < 50) begin
                step();
                n++;
            end
            total++;
            assert (n < 50) else begin
                bad++;
                $error("FAIL t7_reach_w observed=no_wvalid expected=wvalid");
            end
        end
        rst_n = 1'b0;
        #1;
        check("t7_wvalid_reset", o_wvalid, 1'b0);
        check("t7_awvalid_bready_reset", {o_awvalid, o_bready}, 2'b00);
        check("t7_empty_reset", o_wr_buf_empty, 1'b1);
        check("t7_wr_rdy_reset", o_wr_rdy, 1'b1);
        check("t7_bresp_err_reset", o_bresp_err, 1'b0);
        i_chk_addr = 32'h0000_8004; #1;
        check("t7_chk_hit_reset", o_chk_hit, 1'b0);
        aw_q.delete();
        w_q.delete();
        w_cfg = 1'b1;
        step();
        rst_n = 1'b1;
        step();

        // Normal operation after the reset
        push(c_WR_TYPE_LINE, 32'h0000_9000, 4'h0,
             128'h9000_0004_9000_0003_9000_0002_9000_0001);
        wait_idle("t8_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi_wr_buffer.md
# axi_wr_buffer

Posted-write buffer between the dcache write port and the AXI write channels (AW/W/B) of the cache-side AXI bridge. Accepts dcache line evictions and uncached stores in one cycle, queues them in a small FIFO, and drains them in order as single AXI transactions, one outstanding at a time. Drives `wr_buf_empty`, which stalls uncached requests upstream. Provides a same-line hazard flag so the bridge can hold a read that targets a buffered line.

## Interface
- `DEPTH`, 4: FIFO entries, power of two, ≥2.
- `ID_WIDTH`, 4: AXI ID width.
- `AXI_ID`, 1: constant `awid`.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `wr_req` in 1: dcache write request.
- `wr_type` in 3: 000 byte, 001 half, 010 word, 100 cache line (16 B).
- `wr_addr` in 32: byte address; line writes are 16 B aligned.
- `wr_wstrb` in 4: byte strobes, single writes only.
- `wr_data` in 128: line data, word 0 in [31:0]; single writes use [31:0].
- `wr_rdy` out 1: buffer can accept.
- `chk_addr` in 32: read address to hazard-check.
- `chk_hit` out 1: a queued or in-flight entry matches `chk_addr[31:4]`.
- `wr_buf_empty` out 1: no entries, no transaction in flight.
- `bresp_err` out 1: sticky, set on any non-OKAY `bresp`.
- AXI master outputs: `awid` ID_WIDTH, `awaddr` 32, `awlen` 8, `awsize` 3, `awburst` 2, `awlock` 2, `awcache` 4, `awprot` 3, `awvalid` 1, `wid` ID_WIDTH, `wdata` 32, `wstrb` 4, `wlast` 1, `wvalid` 1, `bready` 1.
- AXI master inputs: `awready` 1, `wready` 1, `bid` ID_WIDTH, `bresp` 2, `bvalid` 1.

## Operation
- Push: on `wr_req && wr_rdy`, store {type, addr, wstrb, data} at the tail. `wr_rdy = !full`. No push when full, even if a pop happens in the same cycle.
- Drain FSM: IDLE, AW, W, B.
  - IDLE: go to AW when count ≠ 0. Head entry is latched into the beat registers, and beat counter is cleared.
  - AW: `awvalid=1`. Go to W on `awready`.
  - W: `wvalid=1`. Go to B on `wready && wlast`.
  - B: `bready=1`. On `bvalid`, pop the head and return to IDLE.
- Line entry: `awlen=3`, `awsize=2`, `awburst=01` (INCR), `awaddr` = addr with [3:0] cleared. Beat n sends `wdata = data[32n+31:32n]` with `wstrb=4'hF`. `wlast` is asserted when counter==3.
- Single entry: `awlen=0`, `awsize=wr_type[1:0]`, `awaddr=addr`, `wdata=data[31:0]`, `wstrb=wr_wstrb`, `wlast=1`.
- Constant outputs: `awlock=0`, `awcache=0`, `awprot=0`, `awid=wid=AXI_ID`.
- The head entry stays valid until B completes. Hazard compare covers all valid entries, including the head.
- `chk_hit` is combinational from `chk_addr`.
- `wr_buf_empty = (count==0)`.
- `bid` is ignored. `bresp ≠ 00` sets `bresp_err` until reset.

## Timing
- Reset values: `wr_rdy=1`, `wr_buf_empty=1`, `chk_hit=0` for any address, `bresp_err=0`, all AXI valid/ready outputs 0, FSM in IDLE, counters 0.
- Reset asserted mid-transaction aborts it immediately. All entries are lost and outputs return to their reset values.
- A pushed entry is visible to `chk_hit` and `wr_buf_empty` in the next cycle. The earliest `awvalid` is 2 cycles after the push cycle.
- Payload signals (`awaddr`, `awlen`, `awsize`, `awburst`, `awid`) are stable while `awvalid` is high. `wdata`, `wstrb` and `wlast` are stable while `wvalid` is high, until the handshake.
- Minimum line drain, with all readies high: 1 IDLE cycle, 1 AW cycle, 4 W cycles, 1 B cycle. The pop takes effect the cycle after `bvalid`.
- Simultaneous push and pop when not full: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH. Count width is log2(DEPTH)+1.

## Structure
- Package `axi_wr_pkg`:
  - `WR_TYPE_*` constants.
  - AXI size/burst/response constants.
  - FSM state enum.
  - Entry struct typedef.
- Sub-module `wr_buf_fifo`:
  - Storage array, pointers, count, full/empty flags.
  - Parallel tag compare producing `chk_hit`.
- The top level holds the drain FSM and beat counter.

## Test plan
- Line write at 0x1000, data 0x4444…_3333…_2222…_1111…, all readies high → AW carries addr 0x1000, len 3, size 2, burst 01. W beats carry 0x11111111 through 0x44444444 in order, with wlast on beat 3. `wr_buf_empty` returns to 1 one cycle after `bvalid`.
- Byte store: addr 0x2003, wstrb 1000, data 0xAB000000 → awlen 0, awsize 0, wstrb 1000, wlast on the single beat.
- Push 4 line writes while `awready=0` → `wr_rdy` is 0 after the 4th push. After the first `bvalid`, `wr_rdy` returns to 1, and AXI order matches push order.
- Line 0x3010 queued; `chk_addr`=0x301C gives `chk_hit=1`, `chk_addr`=0x3020 gives `chk_hit=0`. After its B completes, `chk_addr`=0x301C gives `chk_hit=0`.
- `wready` toggles randomly during a burst → no beat is dropped or duplicated, and `wdata` is held while `wvalid && !wready`.
- Reset (low) asserted in the W state with 2 entries queued → `wvalid=0` at once, `wr_buf_empty=1` and `wr_rdy=1`. Once `bresp=10` has been seen, `bresp_err` stays 1 until reset.
